// File: rtl/seq_divider_64by32_pkg.sv
// Shared definitions for the sequential 2W-by-W unsigned divider.
// Holds the default operand width, FSM state encoding, the counter-width helper
// and the all-ones quotient returned on divide-by-zero / overflow fast exits.
package seq_divider_64by32_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step counter must hold 0..W-1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Quotient reported on the exception fast exits.
    localparam logic [W_DEF-1:0] EXC_QUOT = {W_DEF{1'b1}};

endpackage

// File: rtl/seq_divider_64by32_div_step.sv
// One restoring-division step: shift {R,Q} left by one, trial-subtract D, restore on borrow.
// Ports: i_r (W+1 partial remainder), i_q_msb (bit shifted in from Q), i_d (divisor),
//        o_r_next (W+1 updated remainder), o_q_bit (new quotient bit). Purely combinational.
module seq_divider_64by32_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   i_r,
    input  logic         i_q_msb,
    input  logic [W-1:0] i_d,
    output logic [W:0]   o_r_next,
    output logic         o_q_bit
);

    // R < D holds at every step entry, so the top bit of R is always 0 and
    // the shifted value still fits in W+1 bits.
    wire         w_unused_r_msb = i_r[W];
    wire [W:0]   w_r_shift      = {i_r[W-1:0], i_q_msb};
    // W+1-bit trial subtract: a borrow shows up as MSB=1 because |R_shift - D| < 2^W.
    wire [W:0]   w_trial        = w_r_shift - {1'b0, i_d};

    always_comb begin
        o_q_bit  = ~w_trial[W];
        o_r_next = w_trial[W] ? w_r_shift : w_trial;
    end

endmodule

// File: rtl/seq_divider_64by32.sv
// Iterative unsigned restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + remainder.
// Ports: clk/rst (async active-high); in_valid/in_ready + dividend/divisor in;
//        out_valid/out_ready + quotient/remainder/div_by_zero/overflow out. W cycles per result, 1 on exceptions.
module seq_divider_64by32
    import seq_divider_64by32_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = cnt_width(W);
    // Replicating one bit of the all-ones constant keeps it valid for any W.
    localparam logic [W-1:0] C_EXC_QUOT = {W{EXC_QUOT[0]}};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [W:0]     r_rem;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_div;
    logic [W-1:0]   r_quot;
    logic [W-1:0]   r_remo;
    logic           r_dbz;
    logic           r_ovf;

    logic [W:0]     w_r_next;
    logic           w_q_bit;

    wire            w_accept   = in_valid && in_ready;
    wire            w_take     = out_valid && out_ready;
    wire [W-1:0]    w_dvd_hi   = dividend[2*W-1:W];
    wire            w_div_zero = (divisor == '0);
    // Quotient fits in W bits only when the high half is below the divisor.
    wire            w_ovf_in   = (w_dvd_hi >= divisor);
    wire            w_last     = (r_state == ST_RUN) && (r_cnt == CW'(W - 1));
    wire [W-1:0]    w_q_next   = {r_q[W-2:0], w_q_bit};

    seq_divider_64by32_div_step #(.W(W)) u_step (
        .i_r      (r_rem),
        .i_q_msb  (r_q[W-1]),
        .i_d      (r_div),
        .o_r_next (w_r_next),
        .o_q_bit  (w_q_bit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_div_zero || w_ovf_in) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_take) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: working registers plus result registers, which only change on
    // entry to DONE so the result stays stable until it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_remo <= '0;
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quot <= C_EXC_QUOT;
                r_remo <= dividend[W-1:0];
                r_dbz  <= 1'b1;
                r_ovf  <= 1'b0;
            end else if (w_ovf_in) begin
                r_quot <= C_EXC_QUOT;
                r_remo <= dividend[W-1:0];
                r_dbz  <= 1'b0;
                r_ovf  <= 1'b1;
            end else begin
                r_rem <= {1'b0, w_dvd_hi};
                r_q   <= dividend[W-1:0];
                r_div <= divisor;
                r_cnt <= '0;
            end
        end else if (r_state == ST_RUN) begin
            r_rem <= w_r_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_quot <= w_q_next;
                r_remo <= w_r_next[W-1:0];
                r_dbz  <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: doc/seq_divider_64by32.md
Name: seq_divider_64by32

Overview:
Iterative unsigned restoring divider. It is the inverse companion of the 32x32->64 multiplier datapath: it takes a 2W-bit dividend (product width) and a W-bit divisor, and returns a W-bit quotient and a W-bit remainder. It produces one quotient bit per clock and uses valid/ready handshakes on both input and output. Divide-by-zero and quotient overflow are flagged with a fast exit.

Parameters:
W, 32, operand width. Dividend is 2W bits; divisor, quotient and remainder are W bits.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  dividend/divisor are valid
in_ready  output  1  block can accept an operation
dividend  input  2W  unsigned dividend
divisor  input  W  unsigned divisor
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
quotient  output  W  unsigned quotient
remainder  output  W  unsigned remainder
div_by_zero  output  1  divisor was 0
overflow  output  1  quotient does not fit in W bits

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- States: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, step counter=0.
  - quotient, remainder, div_by_zero, overflow, out_valid = 0; in_ready=1 once rst is released.
- in_ready = (state==IDLE). in_valid in RUN or DONE is ignored; nothing is queued.
- Accept: an edge with in_valid && in_ready.
  - divisor==0: go to DONE. div_by_zero=1, overflow=0, quotient={W{1}}, remainder=dividend[W-1:0].
  - Else if dividend[2W-1:W] >= divisor: go to DONE. overflow=1, div_by_zero=0, quotient={W{1}}, remainder=dividend[W-1:0].
  - Else: R (W+1 bits) = {1'b0, dividend[2W-1:W]}; Q = dividend[W-1:0]; latch divisor D; count=0; go to RUN.
- RUN step, one per edge:
  - {R,Q} shifts left by 1 (R takes Q's MSB).
  - T = R_shifted - {1'b0,D} in W+1 bits.
  - If T is non-negative (MSB 0): R=T and Q[0]=1. Else R is kept and Q[0]=0.
  - count increments. After step W (count==W-1), go to DONE with quotient=Q, remainder=R[W-1:0], flags 0.
- Latency:
  - Normal: out_valid is high W cycles after the accept edge (W=32 gives 32 cycles).
  - Exceptions: out_valid is high the cycle after the accept edge.
- DONE:
  - out_valid=1. quotient, remainder and flags stay stable until out_valid && out_ready.
  - On that edge, go to IDLE and out_valid=0. Output data keeps its last value; a sampler must qualify it with out_valid.
- There is no overlap between the output handshake and a new accept: a new operation is accepted one cycle after the result is taken at the earliest. Throughput is W+2 cycles per operation.
- Invariant on a normal result: quotient*divisor + remainder == dividend, and remainder < divisor.
- Width rules:
  - R never exceeds W+1 bits, because the high half is less than the divisor at entry.
  - The subtract is W+1 bits wide; there is no sign extension beyond it.

Decomposition:
- Shared package/header holds:
  - W default;
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - counter width $clog2(W);
  - the exception quotient constant {W{1}}.
- One natural combinational sub-module: div_step. It has inputs R (W+1), q_msb, D (W) and outputs R_next (W+1) and q_bit, implementing the shift/trial-subtract/restore. The top holds the FSM, counter, registers and handshake.

Test Plan:
- dividend=64'd100, divisor=32'd7 -> quotient=14, remainder=2, flags 0; out_valid rises exactly 32 cycles after the accept edge.
- dividend=64'hFFFFFFFE_00000001, divisor=32'hFFFFFFFF -> quotient=32'hFFFFFFFF, remainder=0; then dividend=64'hFFFFFFFE_FFFFFFFF, same divisor -> quotient=32'hFFFFFFFF, remainder=32'hFFFFFFFE.
- divisor=0, dividend=64'h12345678_9ABCDEF0 -> div_by_zero=1, quotient=32'hFFFFFFFF, remainder=32'h9ABCDEF0, out_valid one cycle after accept; dividend=64'h00000001_00000000, divisor=1 -> overflow=1, same fast-exit timing.
- out_ready held low 5 cycles in DONE with in_valid=1 throughout -> outputs stable, in_ready=0, no new accept; on out_ready=1 go to IDLE; in_valid=1 during RUN is never accepted.
- rst pulsed at RUN step 10 -> immediately state IDLE, out_valid=0, all outputs 0, in_ready=1 after release; next op 64'd1000/32'd33 -> quotient=30, remainder=10.
- 1000 random operands with high half < divisor, random out_ready stalls -> every result satisfies quotient*divisor+remainder==dividend and remainder<divisor.
